// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: owns the PC, reads a combinational instruction memory and
// presents each fetched word with its PC to decode through a one-entry valid/ready buffer.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] inst_addr,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    // One extra bit so the limit compare cannot wrap for large memories.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;
    logic [31:0] r_fault_pc;

    logic w_pc_oor;
    logic w_redir_bad;
    logic w_load;

    assign w_pc_oor    = ({1'b0, r_pc} >= PC_LIMIT);
    assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);
    assign w_load      = (r_state == ST_RUN) && (!r_if_valid || if_ready) &&
                         !redirect_valid && !w_pc_oor;

    // Fetch state machine: redirect, run-off fault, load, drain, in that priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'h0000_0000;
            r_if_pc    <= 32'h0000_0000;
            r_fault_pc <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        if (w_redir_bad) begin
                            r_state    <= ST_FAULT;
                            r_fault_pc <= redirect_pc;
                        end else begin
                            r_pc <= redirect_pc;
                        end
                        r_if_valid <= 1'b0;
                    end else if (w_pc_oor) begin
                        // A buffered word still owed to decode is delivered before faulting.
                        if (!r_if_valid || if_ready) begin
                            r_state    <= ST_FAULT;
                            r_fault_pc <= r_pc;
                            r_if_valid <= 1'b0;
                        end else begin
                            r_if_valid <= r_if_valid;
                        end
                    end else if (w_load) begin
                        r_if_inst  <= instruction;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                    end else if (r_if_valid && if_ready) begin
                        r_if_valid <= 1'b0;
                    end else begin
                        r_if_valid <= r_if_valid;
                    end
                end
                ST_FAULT: begin
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_state    <= ST_FAULT;
                    r_if_valid <= 1'b0;
                end
            endcase
        end
    end

    assign inst_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;
    assign fault     = (r_state == ST_FAULT);
    assign fault_pc  = r_fault_pc;

endmodule
